// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit common-segment 7-segment display.
// One hex-to-segment decoder is shared across all digits; a blanking gap precedes every
// digit to prevent ghosting, and the displayed value is double-buffered so that a new
// value only ever appears at a frame boundary.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank digits above the most
// significant nonzero nibble (digit 0 is always shown).

module seven_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_start
);

    localparam int unsigned MaxCnt = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CW     = $clog2(MaxCnt + 1);
    localparam int unsigned IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] DwellLoad = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BlankLoad = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] LastIdx   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pend_valid_q, pend_valid_d;
    logic                    frame_d;
    logic [6:0]              seg_d;
    logic [NUM_DIGITS-1:0]   dig_en_d;
    logic [3:0]              nib;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'b1111110;
            4'h1:    g = 7'b0110000;
            4'h2:    g = 7'b1101101;
            4'h3:    g = 7'b1111001;
            4'h4:    g = 7'b0110011;
            4'h5:    g = 7'b1011011;
            4'h6:    g = 7'b1011111;
            4'h7:    g = 7'b1110000;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1111011;
            4'hA:    g = 7'b1110111;
            4'hB:    g = 7'b0011111;
            4'hC:    g = 7'b1001110;
            4'hD:    g = 7'b0111101;
            4'hE:    g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        return g;
    endfunction

    // Scan sequencing: state, digit index, dwell/blank countdown and frame-entry flag.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        frame_d = 1'b0;
        if (!enable) begin
            state_d = StIdle;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    idx_d   = '0;
                    frame_d = 1'b1;
                    if (BLANK_CYCLES == 0) begin
                        state_d = StShow;
                        cnt_d   = DwellLoad;
                    end else begin
                        state_d = StBlank;
                        cnt_d   = BlankLoad;
                    end
                end
                StBlank: begin
                    if (cnt_q == '0) begin
                        state_d = StShow;
                        cnt_d   = DwellLoad;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                StShow: begin
                    if (cnt_q == '0) begin
                        if (idx_q == LastIdx) begin
                            idx_d   = '0;
                            frame_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                        if (BLANK_CYCLES == 0) begin
                            state_d = StShow;
                            cnt_d   = DwellLoad;
                        end else begin
                            state_d = StBlank;
                            cnt_d   = BlankLoad;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Double buffer: pending value promoted at frame entry; a load at that same edge wins.
    always_comb begin
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (frame_d && pend_valid_q) begin
            disp_d       = pend_q;
            pend_valid_d = 1'b0;
        end
        if (load) begin
            if (state_q == StIdle || frame_d) begin
                // Direct load also retires any older pending value so it cannot resurface.
                disp_d       = value;
                pend_valid_d = 1'b0;
            end else begin
                pend_d       = value;
                pend_valid_d = 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_show;

    // Digit i is visible if it or any higher nibble of the value being shown is nonzero.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        lz_show = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen       = seen | (disp_d[4*i +: 4] != 4'd0);
            lz_show[i] = seen || (i == 0);
        end
    end
`endif

    // Output decode from next state so the registered outputs line up with the state.
    always_comb begin
        seg_d    = '0;
        dig_en_d = '0;
        nib      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                nib = disp_d[4*i +: 4];
            end
        end
        if (state_d == StShow) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig_en_d[i] = (idx_d == IW'(i));
            end
`ifdef LEADING_ZERO_BLANK_EN
            seg_d = lz_show[idx_d] ? hex_glyph(nib) : 7'd0;
`else
            seg_d = hex_glyph(nib);
`endif
        end
    end

    // State, buffers and registered outputs; synchronous reset discards any pending load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cnt_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            seg          <= '0;
            dig_en       <= '0;
            frame_start  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            seg          <= seg_d;
            dig_en       <= dig_en_d;
            frame_start  <= frame_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with NUM_DIGITS=4, DWELL_CYCLES=3, BLANK_CYCLES=1.
// A frame is 16 cycles: per digit one blank cycle followed by three shown cycles.

module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] value;
    logic        load;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    // Expected glyphs packed {digit3, digit2, digit1, digit0}.
    localparam logic [27:0] S1234 = {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011};
    localparam logic [27:0] SABCD = {7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101};
    localparam logic [27:0] S89AB = {7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111};
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [27:0] S0000 = {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110};
    localparam logic [27:0] S0050 = {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110};
`else
    localparam logic [27:0] S0000 = {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110};
    localparam logic [27:0] S0050 = {7'b1111110, 7'b1111110, 7'b1011011, 7'b1111110};
`endif

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .DWELL_CYCLES(3),
        .BLANK_CYCLES(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .value      (value),
        .load       (load),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] es, input logic [3:0] ed,
                       input logic ef);
        checks++;
        assert (seg === es) else begin
            errors++;
            $error("FAIL %s seg got %b want %b", tag, seg, es);
        end
        checks++;
        assert (dig_en === ed) else begin
            errors++;
            $error("FAIL %s dig_en got %b want %b", tag, dig_en, ed);
        end
        checks++;
        assert (frame_start === ef) else begin
            errors++;
            $error("FAIL %s frame_start got %b want %b", tag, frame_start, ef);
        end
    endtask

    // Checks the first ncyc cycles of a frame; optional load strobe sampled for cycle load_at.
    task automatic run_frame(input string tag, input logic [27:0] segs, input int ncyc,
                             input int load_at, input logic [15:0] lval);
        int d;
        int p;
        logic [3:0] oh;
        for (int c = 0; c < ncyc; c++) begin
            d = c / 4;
            p = c % 4;
            if (c == load_at) begin
                load  = 1'b1;
                value = lval;
            end
            tick();
            load = 1'b0;
            oh   = 4'b0001 << d;
            if (p == 0) chk(tag, 7'd0, 4'd0, c == 0);
            else        chk(tag, segs[7*d +: 7], oh, 1'b0);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        load   = 1'b0;
        value  = 16'h0;

        // Reset, then stay disabled.
        tick();
        chk("reset", 7'd0, 4'd0, 1'b0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_dark", 7'd0, 4'd0, 1'b0);
        end

        // Load in IDLE then start scanning.
        value = 16'h1234;
        load  = 1'b1;
        tick();
        chk("idle_load", 7'd0, 4'd0, 1'b0);
        load   = 1'b0;
        enable = 1'b1;
        run_frame("frame_1234", S1234, 16, -1, 16'h0);

        // Load during digit 1: frame unchanged, next frame shows ABCD.
        run_frame("pend_hold", S1234, 16, 6, 16'hABCD);
        run_frame("pend_apply", SABCD, 10, -1, 16'h0);

        // Disable during SHOW of digit 2.
        enable = 1'b0;
        tick();
        chk("disable", 7'd0, 4'd0, 1'b0);
        tick();
        chk("disable2", 7'd0, 4'd0, 1'b0);
        enable = 1'b1;

        // Re-enable, load a pending value, then reset mid-frame.
        run_frame("reenable", SABCD, 6, 2, 16'h00FF);
        reset = 1'b1;
        tick();
        chk("mid_reset", 7'd0, 4'd0, 1'b0);
        reset = 1'b0;
        run_frame("after_reset", S0000, 16, -1, 16'h0);

        // Leading-zero behaviour.
        enable = 1'b0;
        value  = 16'h0050;
        load   = 1'b1;
        tick();
        chk("load_0050", 7'd0, 4'd0, 1'b0);
        load   = 1'b0;
        enable = 1'b1;
        run_frame("frame_0050", S0050, 16, -1, 16'h0);

        // Load coinciding with the frame boundary goes straight to the display.
        run_frame("boundary_load", S89AB, 16, 0, 16'h89AB);

        enable = 1'b0;
        tick();
        chk("final_dark", 7'd0, 4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
